// File: rtl/disp_scan.sv
// Multiplexed 8-digit hex display driver for the four CPU output ports.
// Port values are captured once per full scan so a frame never mixes old and new data.
module disp_scan #(
    parameter int CLK_DIV = 50000,
    parameter bit LZB     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    input  logic [7:0] s4,
    input  logic       blank,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic          load_pend_q, load_pend_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          wrap;
    logic [3:0]    nib;
    logic          digit_off;
    logic [6:0]    hex_seg;

    always_comb begin
        case (nib)
            4'h0:    hex_seg = 7'b1000000;
            4'h1:    hex_seg = 7'b1111001;
            4'h2:    hex_seg = 7'b0100100;
            4'h3:    hex_seg = 7'b0110000;
            4'h4:    hex_seg = 7'b0011001;
            4'h5:    hex_seg = 7'b0010010;
            4'h6:    hex_seg = 7'b0000010;
            4'h7:    hex_seg = 7'b1111000;
            4'h8:    hex_seg = 7'b0000000;
            4'h9:    hex_seg = 7'b0010000;
            4'hA:    hex_seg = 7'b0001000;
            4'hB:    hex_seg = 7'b0000011;
            4'hC:    hex_seg = 7'b1000110;
            4'hD:    hex_seg = 7'b0100001;
            4'hE:    hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    end

    always_comb begin
        wrap        = (pcnt_q == PMAX);
        pcnt_d      = wrap ? '0 : pcnt_q + PW'(1);
        idx_d       = wrap ? idx_q + 3'd1 : idx_q;
        // Snapshot refresh on the edge that wraps idx 7->0, so digit 0 of the next frame sees it
        snap_d      = (load_pend_q || (wrap && idx_q == 3'd7)) ? {s4, s3, s2, s1} : snap_q;
        load_pend_d = 1'b0;

        nib       = snap_q[{idx_q, 2'b00} +: 4];
        digit_off = LZB && idx_q[0] && (nib == 4'h0);

        an_d  = (blank || digit_off) ? 8'hFF : ~(8'b1 << idx_q);
        seg_d = digit_off ? 7'h7F : hex_seg;
        dp_d  = !(!blank && idx_q != 3'd0 && !idx_q[0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q      <= '0;
            idx_q       <= 3'd0;
            snap_q      <= 32'h0;
            load_pend_q <= 1'b1;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
